// File: rtl/mem2axi_pkg.sv
// Shared types and constants for the mem2axi_req bridge.
//   state_e          - bridge FSM states
//   BURST_INCR       - AXI incrementing burst encoding
//   RESP_OKAY/SLVERR - AXI response encodings
//   size_from_width  - AXI beat size field for a given data width
package mem2axi_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StWresp,
    StRaddr,
    StRdata
  } state_e;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // AXI size is log2 of the number of bytes per beat.
  function automatic logic [2:0] size_from_width(input int unsigned data_width);
    return 3'($clog2(data_width / 8));
  endfunction

endpackage

// File: rtl/axi_bus.sv
// AXI4 bus bundle connecting one master to one slave.
//   Master modport drives AW/W/AR payload+valid and B/R ready.
//   Slave modport drives AW/W/AR ready and B/R payload+valid.
interface AXI_BUS #(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 10,
  parameter int unsigned AXI_USER_WIDTH = 10
);

  logic [AXI_ID_WIDTH-1:0]     aw_id;
  logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
  logic [7:0]                  aw_len;
  logic [2:0]                  aw_size;
  logic [1:0]                  aw_burst;
  logic                        aw_lock;
  logic [3:0]                  aw_cache;
  logic [2:0]                  aw_prot;
  logic [3:0]                  aw_qos;
  logic [3:0]                  aw_region;
  logic [AXI_USER_WIDTH-1:0]   aw_user;
  logic                        aw_valid;
  logic                        aw_ready;

  logic [AXI_DATA_WIDTH-1:0]   w_data;
  logic [AXI_DATA_WIDTH/8-1:0] w_strb;
  logic                        w_last;
  logic [AXI_USER_WIDTH-1:0]   w_user;
  logic                        w_valid;
  logic                        w_ready;

  logic [AXI_ID_WIDTH-1:0]     b_id;
  logic [1:0]                  b_resp;
  logic [AXI_USER_WIDTH-1:0]   b_user;
  logic                        b_valid;
  logic                        b_ready;

  logic [AXI_ID_WIDTH-1:0]     ar_id;
  logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
  logic [7:0]                  ar_len;
  logic [2:0]                  ar_size;
  logic [1:0]                  ar_burst;
  logic                        ar_lock;
  logic [3:0]                  ar_cache;
  logic [2:0]                  ar_prot;
  logic [3:0]                  ar_qos;
  logic [3:0]                  ar_region;
  logic [AXI_USER_WIDTH-1:0]   ar_user;
  logic                        ar_valid;
  logic                        ar_ready;

  logic [AXI_ID_WIDTH-1:0]     r_id;
  logic [AXI_DATA_WIDTH-1:0]   r_data;
  logic [1:0]                  r_resp;
  logic                        r_last;
  logic [AXI_USER_WIDTH-1:0]   r_user;
  logic                        r_valid;
  logic                        r_ready;

  modport Master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos,
           aw_region, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos,
           ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport Slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos,
           aw_region, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos,
           ar_region, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );

endinterface

// File: rtl/mem2axi_req.sv
// Bridge from a single-word req/gnt memory port to single-beat AXI4 transactions.
// One transaction in flight at a time; every AXI output comes straight from a register.
//   clk_i, rst_ni         - clock, synchronous active-low reset
//   req_i / gnt_o         - request valid / accepted (combinational, IDLE only)
//   we_i, addr_i, be_i,
//   wdata_i               - request payload
//   rvalid_o, rdata_o,
//   err_o                 - completion pulse, read data (held), error (resp[1])
//   mst                   - AXI4 master port
module mem2axi_req
  import mem2axi_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 10,
  parameter int unsigned AXI_USER_WIDTH = 10,
  parameter int unsigned AXI_ID         = 0
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        req_i,
  output logic                        gnt_o,
  input  logic                        we_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   addr_i,
  input  logic [AXI_DATA_WIDTH/8-1:0] be_i,
  input  logic [AXI_DATA_WIDTH-1:0]   wdata_i,
  output logic                        rvalid_o,
  output logic [AXI_DATA_WIDTH-1:0]   rdata_o,
  output logic                        err_o,
  AXI_BUS.Master                      mst
);

  localparam int unsigned StrbWidth = AXI_DATA_WIDTH / 8;

  state_e                      state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [StrbWidth-1:0]        be_q, be_d;
  logic [AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                        aw_valid_q, aw_valid_d;
  logic                        w_valid_q, w_valid_d;
  logic                        ar_valid_q, ar_valid_d;
  logic                        b_ready_q, b_ready_d;
  logic                        r_ready_q, r_ready_d;
  logic                        rvalid_q, rvalid_d;
  logic                        err_q, err_d;
  logic [AXI_DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                        aw_done, w_done;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    aw_valid_d = aw_valid_q;
    w_valid_d  = w_valid_q;
    ar_valid_d = ar_valid_q;
    b_ready_d  = b_ready_q;
    r_ready_d  = r_ready_q;
    rvalid_d   = 1'b0;
    err_d      = err_q;
    rdata_d    = rdata_q;
    gnt_o      = 1'b0;
    // A channel is done once its valid has dropped or it handshakes this cycle.
    aw_done    = !aw_valid_q || mst.aw_ready;
    w_done     = !w_valid_q || mst.w_ready;

    unique case (state_q)
      StIdle: begin
        gnt_o = req_i;
        if (req_i) begin
          addr_d  = addr_i;
          be_d    = be_i;
          wdata_d = wdata_i;
          if (we_i) begin
            state_d    = StWrite;
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
          end else begin
            state_d    = StRaddr;
            ar_valid_d = 1'b1;
          end
        end
      end
      StWrite: begin
        if (mst.aw_ready) aw_valid_d = 1'b0;
        if (mst.w_ready)  w_valid_d  = 1'b0;
        if (aw_done && w_done) begin
          state_d   = StWresp;
          b_ready_d = 1'b1;
        end
      end
      StWresp: begin
        if (mst.b_valid) begin
          b_ready_d = 1'b0;
          rvalid_d  = 1'b1;
          err_d     = mst.b_resp[1];
          state_d   = StIdle;
        end
      end
      StRaddr: begin
        if (mst.ar_ready) begin
          ar_valid_d = 1'b0;
          r_ready_d  = 1'b1;
          state_d    = StRdata;
        end
      end
      StRdata: begin
        // r_last is ignored: every read is a single beat.
        if (mst.r_valid) begin
          r_ready_d = 1'b0;
          rdata_d   = mst.r_data;
          err_d     = mst.r_resp[1];
          rvalid_d  = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      ar_valid_q <= 1'b0;
      b_ready_q  <= 1'b0;
      r_ready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      aw_valid_q <= aw_valid_d;
      w_valid_q  <= w_valid_d;
      ar_valid_q <= ar_valid_d;
      b_ready_q  <= b_ready_d;
      r_ready_q  <= r_ready_d;
      rvalid_q   <= rvalid_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;

  // Write address channel
  assign mst.aw_id     = AXI_ID_WIDTH'(AXI_ID);
  assign mst.aw_addr   = addr_q;
  assign mst.aw_len    = 8'd0;
  assign mst.aw_size   = size_from_width(AXI_DATA_WIDTH);
  assign mst.aw_burst  = BURST_INCR;
  assign mst.aw_lock   = 1'b0;
  assign mst.aw_cache  = 4'd0;
  assign mst.aw_prot   = 3'd0;
  assign mst.aw_qos    = 4'd0;
  assign mst.aw_region = 4'd0;
  assign mst.aw_user   = '0;
  assign mst.aw_valid  = aw_valid_q;

  // Write data channel
  assign mst.w_data    = wdata_q;
  assign mst.w_strb    = be_q;
  assign mst.w_last    = 1'b1;
  assign mst.w_user    = '0;
  assign mst.w_valid   = w_valid_q;

  assign mst.b_ready   = b_ready_q;

  // Read address channel
  assign mst.ar_id     = AXI_ID_WIDTH'(AXI_ID);
  assign mst.ar_addr   = addr_q;
  assign mst.ar_len    = 8'd0;
  assign mst.ar_size   = size_from_width(AXI_DATA_WIDTH);
  assign mst.ar_burst  = BURST_INCR;
  assign mst.ar_lock   = 1'b0;
  assign mst.ar_cache  = 4'd0;
  assign mst.ar_prot   = 3'd0;
  assign mst.ar_qos    = 4'd0;
  assign mst.ar_region = 4'd0;
  assign mst.ar_user   = '0;
  assign mst.ar_valid  = ar_valid_q;

  assign mst.r_ready   = r_ready_q;

endmodule

// File: tb/tb_mem2axi_req.sv
// Directed bench for mem2axi_req with a small AXI memory slave model.
module tb_mem2axi_req;
  import mem2axi_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, we, gnt, rvalid, err;
  logic [63:0] addr, wdata, rdata;
  logic [7:0]  be;

  int tests = 0;
  int fails = 0;

  AXI_BUS #(
    .AXI_ADDR_WIDTH(64),
    .AXI_DATA_WIDTH(64),
    .AXI_ID_WIDTH  (10),
    .AXI_USER_WIDTH(10)
  ) axi ();

  mem2axi_req #(
    .AXI_ADDR_WIDTH(64),
    .AXI_DATA_WIDTH(64),
    .AXI_ID_WIDTH  (10),
    .AXI_USER_WIDTH(10),
    .AXI_ID        (0)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .req_i   (req),
    .gnt_o   (gnt),
    .we_i    (we),
    .addr_i  (addr),
    .be_i    (be),
    .wdata_i (wdata),
    .rvalid_o(rvalid),
    .rdata_o (rdata),
    .err_o   (err),
    .mst     (axi)
  );

  always #5 clk = ~clk;

  // ---------------- slave model ----------------
  int          aw_delay = 0, w_delay = 0, ar_delay = 0;
  int          aw_cnt, w_cnt, ar_cnt;
  logic [1:0]  b_resp_cfg = RESP_OKAY;
  logic [1:0]  r_resp_cfg = RESP_OKAY;
  logic        mem_clear = 1'b1;
  logic [63:0] mem [16];
  logic        aw_got, w_got;
  logic [63:0] s_addr, s_data;
  logic [7:0]  s_strb;
  int          viol;
  logic        aw_hs, w_hs, ar_hs;
  logic [3:0]  wr_idx;
  logic [63:0] wr_dat;
  logic [7:0]  wr_stb;

  assign axi.aw_ready = (aw_cnt >= aw_delay);
  assign axi.w_ready  = (w_cnt >= w_delay);
  assign axi.ar_ready = (ar_cnt >= ar_delay);
  assign axi.b_id     = '0;
  assign axi.b_user   = '0;
  assign axi.r_id     = '0;
  assign axi.r_user   = '0;
  assign aw_hs = axi.aw_valid && axi.aw_ready;
  assign w_hs  = axi.w_valid && axi.w_ready;
  assign ar_hs = axi.ar_valid && axi.ar_ready;

  always_comb begin
    wr_idx = aw_hs ? axi.aw_addr[15:12] : s_addr[15:12];
    wr_dat = w_hs ? axi.w_data : s_data;
    wr_stb = w_hs ? axi.w_strb : s_strb;
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0;
      axi.b_valid <= 1'b0; axi.r_valid <= 1'b0;
      axi.b_resp <= 2'b00; axi.r_resp <= 2'b00; axi.r_data <= '0; axi.r_last <= 1'b0;
      s_addr <= '0; s_data <= '0; s_strb <= '0;
      if (mem_clear) begin
        viol <= 0;
        for (int i = 0; i < 16; i++) mem[i] <= '0;
      end
    end else begin
      aw_cnt <= (axi.aw_valid && !axi.aw_ready) ? aw_cnt + 1 : 0;
      w_cnt  <= (axi.w_valid && !axi.w_ready) ? w_cnt + 1 : 0;
      ar_cnt <= (axi.ar_valid && !axi.ar_ready) ? ar_cnt + 1 : 0;
      if (axi.ar_valid && (axi.aw_valid || axi.w_valid)) viol <= viol + 1;
      else if (ar_hs && (aw_got || w_got || axi.b_valid || axi.r_valid)) viol <= viol + 1;
      else if ((aw_hs || w_hs) && (axi.r_valid || axi.b_valid)) viol <= viol + 1;
      if (aw_hs) begin aw_got <= 1'b1; s_addr <= axi.aw_addr; end
      if (w_hs) begin w_got <= 1'b1; s_data <= axi.w_data; s_strb <= axi.w_strb; end
      if ((aw_got || aw_hs) && (w_got || w_hs) && !axi.b_valid) begin
        aw_got <= 1'b0; w_got <= 1'b0;
        axi.b_valid <= 1'b1; axi.b_resp <= b_resp_cfg;
        for (int i = 0; i < 8; i++)
          if (wr_stb[i]) mem[wr_idx][8*i +: 8] <= wr_dat[8*i +: 8];
      end else if (axi.b_valid && axi.b_ready) begin
        axi.b_valid <= 1'b0;
      end
      if (ar_hs) begin
        axi.r_valid <= 1'b1; axi.r_data <= mem[axi.ar_addr[15:12]];
        axi.r_resp <= r_resp_cfg; axi.r_last <= 1'b1;
      end else if (axi.r_valid && axi.r_ready) begin
        axi.r_valid <= 1'b0;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a request in IDLE, checks the grant, and leaves the bench in cycle 1.
  task automatic do_req(input logic w, input logic [63:0] a, input logic [7:0] b,
                        input logic [63:0] d, input string tag);
    req = 1'b1; we = w; addr = a; be = b; wdata = d;
    #1;
    chk({tag, "_gnt"}, 64'(gnt), 64'd1);
    step();
    req = 1'b0;
  endtask

  // Cycle index (grant = 0) at which rvalid_o is seen, bounded.
  task automatic wait_rvalid(output int c);
    c = 1;
    while (rvalid !== 1'b1 && c < 40) begin
      step();
      c++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int          c, ng, nr, pulses;
  int          gcyc [4];
  int          rcyc [4];
  logic [63:0] rdv  [4];
  logic        gnt_seen;

  initial begin
    rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0;
    step(); step();
    // Reset state
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_valids", {61'd0, axi.aw_valid, axi.w_valid, axi.ar_valid}, 64'd0);
    chk("rst_readys", {62'd0, axi.b_ready, axi.r_ready}, 64'd0);
    chk("rst_aw_addr", axi.aw_addr, 64'd0);
    rst_n = 1'b1; mem_clear = 1'b0;
    step();

    // Write, always-ready slave
    do_req(1'b1, 64'h1000, 8'hFF, 64'hDEADBEEF_CAFEF00D, "w1");
    chk("w1_aw_valid", 64'(axi.aw_valid), 64'd1);
    chk("w1_w_valid", 64'(axi.w_valid), 64'd1);
    chk("w1_aw_addr", axi.aw_addr, 64'h1000);
    chk("w1_aw_len", 64'(axi.aw_len), 64'd0);
    chk("w1_aw_size", 64'(axi.aw_size), 64'd3);
    chk("w1_aw_burst", 64'(axi.aw_burst), 64'd1);
    chk("w1_aw_id", 64'(axi.aw_id), 64'd0);
    chk("w1_w_strb", 64'(axi.w_strb), 64'hFF);
    chk("w1_w_last", 64'(axi.w_last), 64'd1);
    chk("w1_w_data", axi.w_data, 64'hDEADBEEF_CAFEF00D);
    wait_rvalid(c);
    chk("w1_latency", 64'(c), 64'd3);
    chk("w1_err", 64'(err), 64'd0);
    step();
    chk("w1_pulse_end", 64'(rvalid), 64'd0);

    // Read back
    do_req(1'b0, 64'h1000, 8'h00, 64'd0, "r1");
    chk("r1_ar_valid", 64'(axi.ar_valid), 64'd1);
    chk("r1_ar_addr", axi.ar_addr, 64'h1000);
    chk("r1_ar_size", 64'(axi.ar_size), 64'd3);
    chk("r1_ar_len", 64'(axi.ar_len), 64'd0);
    chk("r1_aw_idle", 64'(axi.aw_valid), 64'd0);
    step();
    chk("r1_r_ready", 64'(axi.r_ready), 64'd1);
    step();
    chk("r1_rvalid_c3", 64'(rvalid), 64'd1);
    chk("r1_rdata", rdata, 64'hDEADBEEF_CAFEF00D);
    chk("r1_err", 64'(err), 64'd0);
    step();
    chk("r1_pulse_end", 64'(rvalid), 64'd0);
    chk("r1_rdata_hold", rdata, 64'hDEADBEEF_CAFEF00D);

    // Delayed AW, immediate W, partial strobes
    aw_delay = 3;
    do_req(1'b1, 64'h3000, 8'h0F, 64'hAAAAAAAA_11111111, "w2");
    chk("w2_c1_valids", {62'd0, axi.aw_valid, axi.w_valid}, 64'h3);
    for (int k = 2; k <= 4; k++) begin
      step();
      chk("w2_w_dropped", 64'(axi.w_valid), 64'd0);
      chk("w2_aw_held", 64'(axi.aw_valid), 64'd1);
      chk("w2_aw_addr_stable", axi.aw_addr, 64'h3000);
      chk("w2_b_ready_early", 64'(axi.b_ready), 64'd0);
    end
    step();
    chk("w2_aw_dropped", 64'(axi.aw_valid), 64'd0);
    chk("w2_b_ready", 64'(axi.b_ready), 64'd1);
    step();
    chk("w2_rvalid", 64'(rvalid), 64'd1);
    aw_delay = 0;
    step();
    do_req(1'b0, 64'h3000, 8'h00, 64'd0, "r2");
    wait_rvalid(c);
    chk("r2_latency", 64'(c), 64'd3);
    chk("r2_strobed_data", rdata, 64'h00000000_11111111);
    step();

    // SLVERR on write, then OKAY read
    b_resp_cfg = RESP_SLVERR;
    do_req(1'b1, 64'h2000, 8'hFF, 64'h55AA55AA_0F0F0F0F, "w3");
    wait_rvalid(c);
    chk("w3_rvalid", 64'(rvalid), 64'd1);
    chk("w3_err", 64'(err), 64'd1);
    b_resp_cfg = RESP_OKAY;
    step();
    // Zero byte enables still produce a write beat
    do_req(1'b1, 64'h2000, 8'h00, 64'hFFFFFFFF_FFFFFFFF, "w4");
    chk("w4_w_valid", 64'(axi.w_valid), 64'd1);
    chk("w4_w_strb", 64'(axi.w_strb), 64'd0);
    wait_rvalid(c);
    chk("w4_latency", 64'(c), 64'd3);
    chk("w4_err", 64'(err), 64'd0);
    step();
    do_req(1'b0, 64'h2000, 8'h00, 64'd0, "r3");
    wait_rvalid(c);
    chk("r3_rvalid", 64'(rvalid), 64'd1);
    chk("r3_err", 64'(err), 64'd0);
    chk("r3_rdata", rdata, 64'h55AA55AA_0F0F0F0F);
    step();

    // req held high across W, R, W
    ng = 0; nr = 0;
    req = 1'b1; we = 1'b1; addr = 64'h4000; be = 8'hFF; wdata = 64'h01234567_89ABCDEF;
    for (int k = 0; k < 14; k++) begin
      #1;
      gnt_seen = gnt;
      if (gnt_seen && ng < 4) begin gcyc[ng] = k; ng++; end
      if (rvalid && nr < 4) begin rcyc[nr] = k; rdv[nr] = rdata; nr++; end
      step();
      if (gnt_seen) begin
        if (ng == 1) begin we = 1'b0; addr = 64'h4000; end
        else if (ng == 2) begin we = 1'b1; addr = 64'h5000; wdata = 64'h0BADF00D_0BADF00D; end
        else req = 1'b0;
      end
    end
    req = 1'b0;
    chk("b2b_grants", 64'(ng), 64'd3);
    chk("b2b_pulses", 64'(nr), 64'd3);
    chk("b2b_gnt0", 64'(gcyc[0]), 64'd0);
    chk("b2b_gnt1", 64'(gcyc[1]), 64'd3);
    chk("b2b_gnt2", 64'(gcyc[2]), 64'd6);
    chk("b2b_rv0", 64'(rcyc[0]), 64'd3);
    chk("b2b_rv1", 64'(rcyc[1]), 64'd6);
    chk("b2b_rv2", 64'(rcyc[2]), 64'd9);
    chk("b2b_read_data", rdv[1], 64'h01234567_89ABCDEF);

    // Reset while waiting in RADDR with a stalled slave
    ar_delay = 1000;
    do_req(1'b0, 64'h1000, 8'h00, 64'd0, "rst");
    step();
    chk("rst_in_raddr", 64'(dut.state_q), 64'(StRaddr));
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rst_mid_valids", {61'd0, axi.aw_valid, axi.w_valid, axi.ar_valid}, 64'd0);
    chk("rst_mid_r_ready", 64'(axi.r_ready), 64'd0);
    chk("rst_mid_state", 64'(dut.state_q), 64'(StIdle));
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      if (rvalid) pulses++;
      step();
    end
    chk("rst_no_pulse", 64'(pulses), 64'd0);
    ar_delay = 0;
    do_req(1'b0, 64'h1000, 8'h00, 64'd0, "post_rst");
    wait_rvalid(c);
    chk("post_rst_latency", 64'(c), 64'd3);
    chk("post_rst_rdata", rdata, 64'hDEADBEEF_CAFEF00D);
    step();

    chk("single_outstanding", 64'(viol), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
